hdc_fusion_bist: RTL and testbench
==================================

# hdc_fusion_bist

On-chip, self-checking traffic engine for `hdc_sensor_fusion`, instantiated beside the fusion core for FPGA bring-up and post-silicon checks. It holds a parametrised table of feature vectors and expected labels, and drives them through the core's `fin_valid`/`fin_ready` handshake. It consumes results on the `dout_valid`/`dout_ready` handshake, optionally applying pseudo-random backpressure on either side. It reports mismatch count, latency statistics, timeout and pass/fail.

## Interface
- `NUM_ENTRY`, 20: depth of the stimulus table.
- `FEATURE_WIDTH`, `TOTAL_NUM_CHANNEL*CHANNEL_WIDTH`: width of a feature vector.
- `NUM_LABELS`, 2: number of label bits per result (bit 0 valence, bit 1 arousal).
- `OUTSTANDING`, 4: number of in-flight entries allowed (timestamp FIFO depth, ≥1).
- `CYCLE_WIDTH`, 32: width of the cycle counter and latency counters.
- `TIMEOUT`, 4096: number of cycles without any handshake in RUN before abort.
- `LFSR_SEED`, 16'hACE1: nonzero seed of the stall LFSR.
- Derived: `AW = ceilLog2(NUM_ENTRY)`, `FW = ceilLog2(NUM_ENTRY*NUM_LABELS+1)`.
- `clk` in 1: single clock, rising edge.
- `rst` in 1: asynchronous, active-low reset.
- `load_en` in 1: table write strobe.
- `load_addr` in AW: table index.
- `load_features` in FEATURE_WIDTH: feature vector to store.
- `load_expected` in NUM_LABELS: expected labels to store.
- `start` in 1: one-cycle pulse that launches a run.
- `mode` in 2: bit0 enables random stall of `fin_valid`; bit1 enables random stall of `dout_ready`. Sampled at `start`.
- `features_top` out FEATURE_WIDTH: feature vector to the core.
- `fin_valid` out 1: feature vector valid.
- `fin_ready` in 1: core ready for a feature vector.
- `labels` in NUM_LABELS: `{arousal, valence}` from the core.
- `dout_valid` in 1: core result valid.
- `dout_ready` out 1: engine ready for a result.
- `busy` out 1: high in RUN.
- `done` out 1: high in DONE.
- `pass` out 1: `done & ~timeout_err & (num_fail==0)`.
- `timeout_err` out 1: run aborted by timeout.
- `num_fail` out FW: number of mismatched label bits.
- `total_latency` out CYCLE_WIDTH: sum of per-entry latencies.
- `max_latency` out CYCLE_WIDTH: largest per-entry latency.
- `cycle` out CYCLE_WIDTH: cycles since `start`.

## Operation
- States: IDLE, RUN, DONE. Reset enters IDLE.
- IDLE or DONE:
  - `load_en` writes the table at `load_addr`. Writes with `load_addr ≥ NUM_ENTRY` are ignored.
  - `load_en` is ignored in RUN.
- `start` in IDLE or DONE moves to RUN. On entry it:
  - clears `cycle`, the statistics, `timeout_err`, and the issue/collect indices;
  - latches `mode`;
  - reloads the LFSR with `LFSR_SEED`.
- `start` during RUN is ignored. If `start` and `load_en` are both high, the load happens and the run starts from the next cycle.
- Issue side:
  - `fin_valid` is asserted when the issue index < NUM_ENTRY, the timestamp FIFO is not full, and there is no stall.
  - `features_top = table[issue index]`.
  - Once `fin_valid` is asserted it is held, with stable data, until `fin_ready`. Stalls only gate new assertions.
  - On `fin_valid & fin_ready`: push `cycle` into the FIFO and increment the issue index.
- Collect side:
  - `dout_ready` is high in RUN unless stalled.
  - On `dout_valid & dout_ready`:
    - pop timestamp `t`; latency = `cycle − t` (mod 2^CYCLE_WIDTH);
    - add the latency to `total_latency` (saturating at all-ones);
    - update `max_latency`;
    - add popcount(`labels ^ expected[collect index]`) to `num_fail`;
    - increment the collect index.
- Stall:
  - 16-bit Fibonacci LFSR with taps 16,14,13,11, advancing every RUN cycle.
  - A stall is active when `lfsr[1:0]==0` and the corresponding `mode` bit is set.
- RUN moves to DONE when the collect index reaches NUM_ENTRY.
- Timeout: the idle counter resets on any handshake. When it reaches TIMEOUT, set `timeout_err` and move to DONE.
- A `dout_valid` handshake with an empty FIFO is a protocol error: count NUM_LABELS failures and do not pop.

## Timing
- All outputs are registered. Reset value of every output is 0, including `features_top`.
- `start` at cycle N: `busy` is high at N+1; the first `fin_valid` is at the earliest N+1.
- The FIFO push at the fin handshake in cycle k is visible to a pop in cycle k+1. A same-cycle push and pop on a full FIFO is allowed.
- `done`/`pass` rise one cycle after the final dout handshake or after timeout. They hold until `start` or reset.
- `cycle` increments every RUN cycle and freezes in DONE.
- Reset asserted mid-run: immediate return to IDLE with all outputs 0. Table contents are undefined after reset.

## Test plan
- Ideal core model with fixed latency 3, mode=0, 20 entries with all labels matching → `pass=1`, `num_fail=0`, `max_latency=3`, `total_latency=60`.
- Invert valence on entries 2 and 7 and both labels on entry 11 → `num_fail=4`, `pass=0`.
- Core holds `fin_ready=0` for 4096 cycles after entry 5 → `timeout_err=1`, `done=1`, `pass=0`.
- mode=3 with seed 16'hACE1 → `fin_valid` stays stable while stalled and no data changes occur while valid; final counters match mode=0 except the latency figures.
- Core latency 10, OUTSTANDING=4 → never more than 4 issued-but-uncollected entries; `fin_valid` low while the FIFO is full.
- Assert `rst` in the middle of entry 9, then load and start again → clean rerun; `cycle` restarts at 0 and results are identical.

Source files
------------

// File: rtl/hdc_fusion_bist.sv
// hdc_fusion_bist: self-checking traffic engine for hdc_sensor_fusion.
// Holds a table of feature vectors and expected labels. Each run sends every entry into the core
// over fin_valid/fin_ready and collects the results over dout_valid/dout_ready. Either side can
// be stalled at random by an LFSR. The run reports label mismatches, latency and timeout.
// Ports:
//   clk, rst (async, active-low)
//   load_en/load_addr/load_features/load_expected : table write port (IDLE/DONE only)
//   start, mode                                    : run launch; mode[0]/[1] = issue/collect stall
//   features_top, fin_valid, fin_ready             : stimulus handshake to the core
//   labels, dout_valid, dout_ready                 : result handshake from the core
//   busy, done, pass, timeout_err                  : run status
//   num_fail, total_latency, max_latency, cycle    : run statistics
module hdc_fusion_bist #(
    parameter int unsigned NUM_ENTRY         = 20,
    parameter int unsigned TOTAL_NUM_CHANNEL = 4,
    parameter int unsigned CHANNEL_WIDTH     = 8,
    parameter int unsigned FEATURE_WIDTH     = TOTAL_NUM_CHANNEL * CHANNEL_WIDTH,
    parameter int unsigned NUM_LABELS        = 2,
    parameter int unsigned OUTSTANDING       = 4,
    parameter int unsigned CYCLE_WIDTH       = 32,
    parameter int unsigned TIMEOUT           = 4096,
    parameter logic [15:0] LFSR_SEED         = 16'hACE1,
    localparam int unsigned AW = (NUM_ENTRY > 1) ? $clog2(NUM_ENTRY) : 1,
    localparam int unsigned FW = $clog2(NUM_ENTRY * NUM_LABELS + 1)
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     load_en,
    input  logic [AW-1:0]            load_addr,
    input  logic [FEATURE_WIDTH-1:0] load_features,
    input  logic [NUM_LABELS-1:0]    load_expected,
    input  logic                     start,
    input  logic [1:0]               mode,
    output logic [FEATURE_WIDTH-1:0] features_top,
    output logic                     fin_valid,
    input  logic                     fin_ready,
    input  logic [NUM_LABELS-1:0]    labels,
    input  logic                     dout_valid,
    output logic                     dout_ready,
    output logic                     busy,
    output logic                     done,
    output logic                     pass,
    output logic                     timeout_err,
    output logic [FW-1:0]            num_fail,
    output logic [CYCLE_WIDTH-1:0]   total_latency,
    output logic [CYCLE_WIDTH-1:0]   max_latency,
    output logic [CYCLE_WIDTH-1:0]   cycle
);
    localparam int unsigned IW  = $clog2(NUM_ENTRY + 1);
    localparam int unsigned PW  = (OUTSTANDING > 1) ? $clog2(OUTSTANDING) : 1;
    localparam int unsigned CNW = $clog2(OUTSTANDING + 1);
    localparam int unsigned TW  = $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

    logic [FEATURE_WIDTH-1:0] feat_mem [NUM_ENTRY];
    logic [NUM_LABELS-1:0]    exp_mem  [NUM_ENTRY];
    logic [CYCLE_WIDTH-1:0]   ts_mem   [OUTSTANDING];

    state_e                   state_q, state_d;
    logic [IW-1:0]            issue_q, issue_d, collect_q, collect_d;
    logic [PW-1:0]            wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CNW-1:0]           cnt_q, cnt_d;
    logic [TW-1:0]            idle_q, idle_d;
    logic [15:0]              lfsr_q, lfsr_d;
    logic [1:0]               mode_q, mode_d;
    logic [FEATURE_WIDTH-1:0] feat_q, feat_d;
    logic                     fin_valid_q, fin_valid_d, dout_ready_q, dout_ready_d;
    logic                     busy_q, busy_d, done_q, done_d, pass_q, pass_d, tmo_q, tmo_d;
    logic [FW-1:0]            nf_q, nf_d;
    logic [CYCLE_WIDTH-1:0]   tot_q, tot_d, max_q, max_d, cyc_q, cyc_d;

    logic                     fin_hs, dout_hs, pop;
    logic                     stall_issue, stall_collect;
    logic [CYCLE_WIDTH-1:0]   lat;
    logic [CYCLE_WIDTH:0]     lat_sum;
    logic [NUM_LABELS-1:0]    diff;
    logic [FW-1:0]            mism;

    // Table writes are blocked while a run is using the table.
    always_ff @(posedge clk) begin
        if (load_en && state_q != StRun && 32'(load_addr) < NUM_ENTRY) begin
            feat_mem[load_addr] <= load_features;
            exp_mem[load_addr]  <= load_expected;
        end
    end

    always_ff @(posedge clk) begin
        if (fin_hs) begin
            ts_mem[wr_ptr_q] <= cyc_q;
        end
    end

    always_comb begin
        state_d      = state_q;
        issue_d      = issue_q;
        collect_d    = collect_q;
        wr_ptr_d     = wr_ptr_q;
        rd_ptr_d     = rd_ptr_q;
        cnt_d        = cnt_q;
        idle_d       = idle_q;
        lfsr_d       = lfsr_q;
        mode_d       = mode_q;
        feat_d       = feat_q;
        fin_valid_d  = fin_valid_q;
        dout_ready_d = dout_ready_q;
        tmo_d        = tmo_q;
        nf_d         = nf_q;
        tot_d        = tot_q;
        max_d        = max_q;
        cyc_d        = cyc_q;

        fin_hs        = (state_q == StRun) && fin_valid_q && fin_ready;
        dout_hs       = (state_q == StRun) && dout_ready_q && dout_valid;
        pop           = dout_hs && (cnt_q != '0);
        stall_issue   = mode_q[0] && (lfsr_q[1:0] == 2'b00);
        stall_collect = mode_q[1] && (lfsr_q[1:0] == 2'b00);
        lat           = cyc_q - ts_mem[rd_ptr_q];
        lat_sum       = {1'b0, tot_q} + {1'b0, lat};
        diff          = labels ^ exp_mem[collect_q[AW-1:0]];
        mism          = '0;
        for (int unsigned i = 0; i < NUM_LABELS; i++) begin
            mism = mism + FW'(diff[i]);
        end

        unique case (state_q)
            StIdle, StDone: begin
                if (start) begin
                    state_d      = StRun;
                    issue_d      = '0;
                    collect_d    = '0;
                    wr_ptr_d     = '0;
                    rd_ptr_d     = '0;
                    cnt_d        = '0;
                    idle_d       = '0;
                    lfsr_d       = LFSR_SEED;
                    mode_d       = mode;
                    fin_valid_d  = 1'b0;
                    dout_ready_d = !(mode[1] && (LFSR_SEED[1:0] == 2'b00));
                    tmo_d        = 1'b0;
                    nf_d         = '0;
                    tot_d        = '0;
                    max_d        = '0;
                    cyc_d        = '0;
                end
            end
            StRun: begin
                cyc_d  = cyc_q + 1'b1;
                lfsr_d = {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};
                if (fin_hs) begin
                    issue_d  = issue_q + 1'b1;
                    wr_ptr_d = (wr_ptr_q == PW'(OUTSTANDING - 1)) ? '0 : wr_ptr_q + PW'(1);
                end
                if (dout_hs) begin
                    collect_d = collect_q + 1'b1;
                    if (pop) begin
                        rd_ptr_d = (rd_ptr_q == PW'(OUTSTANDING - 1)) ? '0 : rd_ptr_q + PW'(1);
                        tot_d    = lat_sum[CYCLE_WIDTH] ? '1 : lat_sum[CYCLE_WIDTH-1:0];
                        max_d    = (lat > max_q) ? lat : max_q;
                        nf_d     = nf_q + mism;
                    end else begin
                        // Result with no matching issue: every label counts as wrong.
                        nf_d = nf_q + FW'(NUM_LABELS);
                    end
                end
                if (fin_hs && !pop) begin
                    cnt_d = cnt_q + CNW'(1);
                end else if (!fin_hs && pop) begin
                    cnt_d = cnt_q - CNW'(1);
                end
                idle_d = (fin_hs || dout_hs) ? '0 : idle_q + TW'(1);

                // A presented vector is held until accepted; stalls only block new offers.
                if (!(fin_valid_q && !fin_ready)) begin
                    fin_valid_d = (issue_d < IW'(NUM_ENTRY)) && (cnt_d < CNW'(OUTSTANDING)) &&
                                  !stall_issue;
                    if (fin_valid_d) begin
                        feat_d = feat_mem[issue_d[AW-1:0]];
                    end
                end
                dout_ready_d = !stall_collect;

                if (collect_d == IW'(NUM_ENTRY)) begin
                    state_d      = StDone;
                    fin_valid_d  = 1'b0;
                    dout_ready_d = 1'b0;
                end else if (!fin_hs && !dout_hs && idle_q == TW'(TIMEOUT - 1)) begin
                    state_d      = StDone;
                    tmo_d        = 1'b1;
                    fin_valid_d  = 1'b0;
                    dout_ready_d = 1'b0;
                end
            end
            default: state_d = StIdle;
        endcase

        busy_d = (state_d == StRun);
        done_d = (state_d == StDone);
        pass_d = done_d && !tmo_d && (nf_d == '0);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= StIdle;
            issue_q      <= '0;
            collect_q    <= '0;
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            cnt_q        <= '0;
            idle_q       <= '0;
            lfsr_q       <= LFSR_SEED;
            mode_q       <= '0;
            feat_q       <= '0;
            fin_valid_q  <= 1'b0;
            dout_ready_q <= 1'b0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            pass_q       <= 1'b0;
            tmo_q        <= 1'b0;
            nf_q         <= '0;
            tot_q        <= '0;
            max_q        <= '0;
            cyc_q        <= '0;
        end else begin
            state_q      <= state_d;
            issue_q      <= issue_d;
            collect_q    <= collect_d;
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            cnt_q        <= cnt_d;
            idle_q       <= idle_d;
            lfsr_q       <= lfsr_d;
            mode_q       <= mode_d;
            feat_q       <= feat_d;
            fin_valid_q  <= fin_valid_d;
            dout_ready_q <= dout_ready_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
            pass_q       <= pass_d;
            tmo_q        <= tmo_d;
            nf_q         <= nf_d;
            tot_q        <= tot_d;
            max_q        <= max_d;
            cyc_q        <= cyc_d;
        end
    end

    assign features_top  = feat_q;
    assign fin_valid     = fin_valid_q;
    assign dout_ready    = dout_ready_q;
    assign busy          = busy_q;
    assign done          = done_q;
    assign pass          = pass_q;
    assign timeout_err   = tmo_q;
    assign num_fail      = nf_q;
    assign total_latency = tot_q;
    assign max_latency   = max_q;
    assign cycle         = cyc_q;

endmodule

// File: tb/tb_hdc_fusion_bist.sv
// tb_hdc_fusion_bist: bench for hdc_fusion_bist with a fixed-latency core model.
// Expected feature vectors and expected end-of-run results are queued when a run is launched;
// a negedge monitor pops them when the DUT hands over a vector or raises done.
module tb_hdc_fusion_bist;
    localparam int NE  = 20;
    localparam int OST = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        load_en = 1'b0;
    logic [4:0]  load_addr = '0;
    logic [31:0] load_features = '0;
    logic [1:0]  load_expected = '0;
    logic        start = 1'b0;
    logic [1:0]  mode = '0;
    logic [31:0] features_top;
    logic        fin_valid;
    logic        fin_ready = 1'b0;
    logic [1:0]  labels = '0;
    logic        dout_valid = 1'b0;
    logic        dout_ready;
    logic        busy, done, pass, timeout_err;
    logic [5:0]  num_fail;
    logic [31:0] total_latency, max_latency, cycle;

    always #5 clk = ~clk;

    hdc_fusion_bist #(
        .NUM_ENTRY(NE), .TOTAL_NUM_CHANNEL(4), .CHANNEL_WIDTH(8), .NUM_LABELS(2),
        .OUTSTANDING(OST), .CYCLE_WIDTH(32), .TIMEOUT(4096), .LFSR_SEED(16'hACE1)
    ) dut (
        .clk(clk), .rst(rst), .load_en(load_en), .load_addr(load_addr),
        .load_features(load_features), .load_expected(load_expected), .start(start),
        .mode(mode), .features_top(features_top), .fin_valid(fin_valid), .fin_ready(fin_ready),
        .labels(labels), .dout_valid(dout_valid), .dout_ready(dout_ready), .busy(busy),
        .done(done), .pass(pass), .timeout_err(timeout_err), .num_fail(num_fail),
        .total_latency(total_latency), .max_latency(max_latency), .cycle(cycle)
    );

    typedef struct {
        int         due;
        logic [1:0] lbl;
    } tok_t;

    typedef struct {
        logic        pass;
        logic        tmo;
        logic [5:0]  nf;
        logic [31:0] tot;
        logic [31:0] mx;
        bit          chk_lat;
    } res_t;

    int n_pass  = 0;
    int n_total = 0;

    tok_t        core_q[$];
    logic [31:0] feat_exp_q[$];
    res_t        res_q[$];
    tok_t        tok;
    res_t        r;

    int          cyc = 0, hs_cnt = 0, inflight = 0, max_inflight = 0;
    int          run_id = 0, run_seen = 0;
    int          core_lat = 3, ready_pol = 0;
    logic [1:0]  corrupt [NE];
    logic        hold_prev = 1'b0, done_prev = 1'b0;
    logic [31:0] feat_prev = '0;

    task automatic cmp(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
    endtask

    function automatic logic [31:0] feat_of(input int i);
        return {8'(i * 13 + 1), 8'(~i), 8'(i ^ 'h5A), 6'(i), 2'(i * 3)};
    endfunction

    // Core model and monitor: fixed-latency core whose labels are the low two feature bits,
    // optionally corrupted per entry.
    always @(negedge clk) begin
        if (!rst) begin
            core_q.delete();
            inflight   = 0;
            hs_cnt     = 0;
            fin_ready  = 1'b0;
            dout_valid = 1'b0;
            labels     = '0;
            hold_prev  = 1'b0;
            done_prev  = 1'b0;
        end else begin
            cyc++;
            if (run_seen != run_id) begin
                run_seen = run_id;
                hs_cnt = 0;
                inflight = 0;
                max_inflight = 0;
                core_q.delete();
            end
            case (ready_pol)
                1:       fin_ready = (hs_cnt < 6);
                2:       fin_ready = ((cyc % 3) != 0);
                default: fin_ready = 1'b1;
            endcase
            if (core_q.size() > 0 && core_q[0].due <= cyc) begin
                dout_valid = 1'b1;
                labels     = core_q[0].lbl;
            end else begin
                dout_valid = 1'b0;
                labels     = '0;
            end

            if (hold_prev && busy) begin
                cmp("fin_valid_hold", fin_valid, 1);
                cmp("features_hold", features_top, feat_prev);
            end
            if (inflight >= OST) cmp("fin_valid_when_full", fin_valid, 0);

            if (fin_valid && fin_ready) begin
                if (feat_exp_q.size() > 0) begin
                    cmp("features", features_top, feat_exp_q.pop_front());
                end else begin
                    n_total++;
                    $display("FAIL features: unexpected issue %0h, expected none", features_top);
                end
                tok.due = cyc + core_lat;
                tok.lbl = features_top[1:0] ^ ((hs_cnt < NE) ? corrupt[hs_cnt] : 2'b00);
                core_q.push_back(tok);
                hs_cnt++;
                inflight++;
            end
            if (dout_valid && dout_ready) begin
                void'(core_q.pop_front());
                inflight--;
            end
            if (inflight > max_inflight) max_inflight = inflight;
            hold_prev = fin_valid && !fin_ready;
            feat_prev = features_top;

            if (done && !done_prev) begin
                if (res_q.size() > 0) begin
                    r = res_q.pop_front();
                    cmp("busy_at_done", busy, 0);
                    cmp("pass", pass, r.pass);
                    cmp("timeout_err", timeout_err, r.tmo);
                    cmp("num_fail", num_fail, r.nf);
                    if (r.chk_lat) begin
                        cmp("total_latency", total_latency, r.tot);
                        cmp("max_latency", max_latency, r.mx);
                    end
                end else begin
                    n_total++;
                    $display("FAIL done: unexpected done rise, expected none");
                end
            end
            done_prev = done;
        end
    end

    task automatic load_table();
        for (int i = 0; i < NE; i++) begin
            load_en       = 1'b1;
            load_addr     = 5'(i);
            load_features = feat_of(i);
            load_expected = 2'(i * 3);
            @(negedge clk);
        end
        load_en = 1'b0;
    endtask

    task automatic prep_run(input int lat, input int pol);
        core_lat  = lat;
        ready_pol = pol;
        feat_exp_q.delete();
        for (int i = 0; i < NE; i++) feat_exp_q.push_back(feat_of(i));
        run_id++;
    endtask

    task automatic run_test(input int lat, input int pol, input logic [1:0] md,
                            input logic [5:0] nf, input logic tmo, input logic [31:0] tot,
                            input logic [31:0] mx, input bit chk_lat, input bit stray);
        res_t e;
        int   k;
        prep_run(lat, pol);
        e.pass = !tmo && (nf == 0);
        e.tmo = tmo;
        e.nf = nf;
        e.tot = tot;
        e.mx = mx;
        e.chk_lat = chk_lat;
        res_q.push_back(e);
        @(negedge clk);
        start = 1'b1;
        mode  = md;
        @(negedge clk);
        start = 1'b0;
        cmp("busy_after_start", busy, 1);
        cmp("cycle_at_start", cycle, 0);
        if (stray) begin
            // Loads and starts during a run must not disturb it.
            load_en = 1'b1; load_addr = 5'd19; load_features = 32'hDEAD_BEEF; load_expected = 2'b10;
            @(negedge clk);
            load_en = 1'b0;
            repeat (4) @(negedge clk);
            start = 1'b1;
            @(negedge clk);
            start = 1'b0;
        end
        k = 0;
        while (!done && k < 8000) begin
            @(negedge clk);
            k++;
        end
        if (!done) begin
            n_total++;
            $display("FAIL run_done: done=0 after %0d cycles, expected 1", k);
        end
        repeat (2) @(negedge clk);
    endtask

    task automatic check_reset_state(input string tag);
        cmp({tag, "_features_top"}, features_top, 0);
        cmp({tag, "_fin_valid"}, fin_valid, 0);
        cmp({tag, "_dout_ready"}, dout_ready, 0);
        cmp({tag, "_busy"}, busy, 0);
        cmp({tag, "_done"}, done, 0);
        cmp({tag, "_pass"}, pass, 0);
        cmp({tag, "_timeout_err"}, timeout_err, 0);
        cmp({tag, "_num_fail"}, num_fail, 0);
        cmp({tag, "_total_latency"}, total_latency, 0);
        cmp({tag, "_max_latency"}, max_latency, 0);
        cmp({tag, "_cycle"}, cycle, 0);
    endtask

    initial begin
        int k;
        for (int i = 0; i < NE; i++) corrupt[i] = 2'b00;
        repeat (3) @(negedge clk);
        check_reset_state("reset");
        rst = 1'b1;
        @(negedge clk);
        load_table();

        // All labels match, fixed latency 3, stray load/start mid-run.
        run_test(3, 0, 2'b00, 6'd0, 1'b0, 32'd60, 32'd3, 1'b1, 1'b1);

        // Valence wrong on entries 2 and 7, both labels wrong on 11.
        corrupt[2] = 2'b01; corrupt[7] = 2'b01; corrupt[11] = 2'b11;
        run_test(3, 0, 2'b00, 6'd4, 1'b0, 32'd60, 32'd3, 1'b1, 1'b0);
        for (int i = 0; i < NE; i++) corrupt[i] = 2'b00;

        // Core stops accepting after entry 5.
        run_test(3, 1, 2'b00, 6'd0, 1'b1, 32'd18, 32'd3, 1'b1, 1'b0);

        // Random stalls on both sides plus a gappy fin_ready.
        run_test(3, 2, 2'b11, 6'd0, 1'b0, 32'd0, 32'd0, 1'b0, 1'b0);

        // Latency longer than the outstanding window.
        run_test(10, 0, 2'b00, 6'd0, 1'b0, 32'd200, 32'd10, 1'b1, 1'b0);
        cmp("max_inflight", max_inflight, OST);

        // Reset in the middle of entry 9, then reload and rerun.
        prep_run(3, 0);
        @(negedge clk);
        start = 1'b1;
        mode  = 2'b00;
        @(negedge clk);
        start = 1'b0;
        k = 0;
        while (hs_cnt < 10 && k < 200) begin
            @(negedge clk);
            k++;
        end
        if (hs_cnt < 10) begin
            n_total++;
            $display("FAIL mid_run_issue: %0d entries issued, expected 10", hs_cnt);
        end
        rst = 1'b0;
        @(negedge clk);
        check_reset_state("midreset");
        rst = 1'b1;
        @(negedge clk);
        load_table();
        run_test(3, 0, 2'b00, 6'd0, 1'b0, 32'd60, 32'd3, 1'b1, 1'b0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation still running at %0t, expected finish", $time);
        $fatal(1, "watchdog expired");
    end

endmodule
